// File: rtl/cs_pkg.sv
// ---------------------------------------------------------------------------
// cs_pkg
// Definitions shared by the command-sequencer movers (fifod2mac and its
// receive counterpart):
//   - 8-bit mover state encodings, also visible on debug taps
//   - default byte-lane and length widths
//   - the fs/fd handshake convention used between sequencer and movers
//
// fs/fd handshake:
//   The sequencer raises fs_* (level) and holds it until it sees fd_*.
//   The mover raises fd_* (level) when its job is finished and holds it
//   until it samples fs_* low. fd_* drops on the cycle after fs_* is
//   sampled low, which returns the mover to idle.
// ---------------------------------------------------------------------------
package cs_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int LEN_WIDTH_DEF  = 16;

   // Depth of the output buffer between the FIFO read port and the MAC.
   localparam int SKID_DEPTH = 2;

   typedef enum logic [7:0] {
      ST_IDLE = 8'h00,
      ST_PREP = 8'h01,
      ST_SEND = 8'h02,
      ST_DONE = 8'h03
   } cs_state_t;

   // True when the sequencer requests a new job.
   function automatic logic hs_request(input logic fs);
      return fs;
   endfunction

   // True when the sequencer has acknowledged fd by dropping fs.
   function automatic logic hs_released(input logic fs);
      return ~fs;
   endfunction

endpackage

// File: rtl/fifod2mac_skid.sv
// ---------------------------------------------------------------------------
// fifod2mac_skid
// Two-entry output buffer between the FIFO D read port and the MAC TX
// byte stream. Entries are pushed one cycle after each FIFO read strobe
// (when the read data is valid) and popped by the valid/ready handshake
// on the MAC side. The head entry drives the MAC directly from a
// register, so data is stable while the MAC stalls.
//
// Ports:
//   sys_clk     in   clock, rising edge
//   rst         in   synchronous active-high reset, empties the buffer
//   push        in   write push_data this cycle
//   push_data   in   byte from the FIFO read port
//   out_valid   out  head entry is valid
//   out_data    out  head entry byte
//   out_ready   in   downstream accept
//   occupancy   out  number of valid entries (0..2)
//
// The caller must never push into a full buffer unless it is also
// popping in the same cycle.
// ---------------------------------------------------------------------------
module fifod2mac_skid
   import cs_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [1:0]            occupancy
);

   logic [DATA_WIDTH-1:0] head_q;
   logic [DATA_WIDTH-1:0] tail_q;
   logic [1:0]            count_q;
   logic                  pop;

   assign out_valid = (count_q != 2'd0);
   assign out_data  = head_q;
   assign occupancy = count_q;
   assign pop       = out_valid & out_ready;

   // head_q is always the oldest byte; tail_q holds the second one when
   // the buffer is full. A pop shifts tail into head.
   // NOTE: the two data entries are reset along with the count because the
   // MAC-side byte must read as zero out of reset; a deep memory would not be.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) begin
                  head_q <= push_data;
               end else begin
                  tail_q <= push_data;
               end
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               head_q  <= tail_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               // Occupancy is unchanged; the new byte lands behind
               // whatever remains after the pop.
               if (count_q == 2'd1) begin
                  head_q <= push_data;
               end else begin
                  head_q <= tail_q;
                  tail_q <= push_data;
               end
            end
            default: begin
               count_q <= count_q;
            end
         endcase
      end
   end

endmodule

// File: rtl/fifod2mac.sv
// ---------------------------------------------------------------------------
// fifod2mac
// Transmit-path mover. While the sequencer holds fs_fifod2mac, drains one
// frame of data_len bytes from FIFO D (standard-mode read port, data valid
// the cycle after the read strobe) and streams it to the MAC/UDP TX
// valid/ready byte interface, then returns fd_fifod2mac.
//
// Ports:
//   sys_clk       in   clock, rising edge
//   rst           in   synchronous active-high reset
//   fs_fifod2mac  in   start request (level, held until fd)
//   fd_fifod2mac  out  done flag (level, held until fs drops)
//   data_len      in   frame length in bytes, latched at start
//   fifo_cnt      in   FIFO D occupancy
//   fifo_rd_en    out  FIFO D read strobe
//   fifo_rd_data  in   FIFO D read data (one cycle after fifo_rd_en)
//   mac_tx_valid  out  TX byte valid
//   mac_tx_data   out  TX byte
//   mac_tx_last   out  final byte of the frame
//   mac_tx_ready  in   TX accept
//   frame_cnt     out  completed-frame counter (wraps), debug tap
//
// The frame is only started once FIFO D holds all of it, so the read
// stream can never underflow mid-frame. Reads are throttled so the
// two-entry output buffer can never overflow.
// ---------------------------------------------------------------------------
module fifod2mac
   import cs_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  fs_fifod2mac,
   output logic                  fd_fifod2mac,
   input  logic [LEN_WIDTH-1:0]  data_len,
   input  logic [LEN_WIDTH-1:0]  fifo_cnt,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  mac_tx_valid,
   output logic [DATA_WIDTH-1:0] mac_tx_data,
   output logic                  mac_tx_last,
   input  logic                  mac_tx_ready,
   output logic [7:0]            frame_cnt
);

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   cs_state_t             state_q;
   cs_state_t             state_d;
   logic [LEN_WIDTH-1:0]  len_r;
   logic [LEN_WIDTH-1:0]  rd_cnt;
   logic [LEN_WIDTH-1:0]  tx_cnt;
   logic                  rd_pending;
   logic [7:0]            frame_cnt_q;
   logic [1:0]            buf_occ;
   logic [2:0]            slots_after;
   logic                  tx_accept;
   logic                  enter_send;
   logic                  frame_done;

   // -------------------------------------------------------------------
   // Output buffer
   // -------------------------------------------------------------------
   fifod2mac_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .push      (rd_pending),
      .push_data (fifo_rd_data),
      .out_valid (mac_tx_valid),
      .out_data  (mac_tx_data),
      .out_ready (mac_tx_ready),
      .occupancy (buf_occ)
   );

   assign tx_accept   = mac_tx_valid & mac_tx_ready;
   assign mac_tx_last = mac_tx_valid & (tx_cnt == (len_r - LEN_ONE));

   // Buffer slots still committed after this cycle: bytes held plus the
   // read in flight, minus the byte the MAC takes now. Counting the
   // current pop is what lets a new read go out every cycle while the
   // MAC keeps ready high.
   assign slots_after = {1'b0, buf_occ} + {2'b00, rd_pending} - {2'b00, tx_accept};

   assign fifo_rd_en = (state_q == ST_SEND) && (rd_cnt < len_r) && (slots_after < 3'd2);

   assign enter_send = (state_q == ST_PREP) && (state_d == ST_SEND);
   assign frame_done = (state_d == ST_DONE) &&
                       ((state_q == ST_SEND) || (state_q == ST_IDLE));

   assign fd_fifod2mac = (state_q == ST_DONE);
   assign frame_cnt    = frame_cnt_q;

   // -------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: state_d gets its default before the case so that no path
   // through this block leaves it unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (hs_request(fs_fifod2mac)) begin
               state_d = (data_len == '0) ? ST_DONE : ST_PREP;
            end
         end
         ST_PREP: begin
            // Oversized frames wait here until reset.
            if (fifo_cnt >= len_r) begin
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_accept && mac_tx_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (hs_released(fs_fifod2mac)) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------
   // Length latch, read/accept counters, frame counter
   // -------------------------------------------------------------------
   // NOTE: non-blocking assignments throughout so every register here
   // updates from pre-edge values, independent of statement order.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         len_r       <= '0;
         rd_cnt      <= '0;
         tx_cnt      <= '0;
         rd_pending  <= 1'b0;
         frame_cnt_q <= 8'h00;
      end else begin
         // A cleared rd_pending also drops any byte still in flight
         // from the FIFO when a reset interrupts a frame.
         rd_pending <= fifo_rd_en;

         if ((state_q == ST_IDLE) && hs_request(fs_fifod2mac)) begin
            len_r <= data_len;
         end

         if (enter_send) begin
            rd_cnt <= '0;
            tx_cnt <= '0;
         end else begin
            if (fifo_rd_en) begin
               rd_cnt <= rd_cnt + LEN_ONE;
            end
            if (tx_accept) begin
               tx_cnt <= tx_cnt + LEN_ONE;
            end
         end

         if (frame_done) begin
            frame_cnt_q <= frame_cnt_q + 8'h01;
         end
      end
   end

endmodule
